// File: rtl/job_pkg.sv
// Shared definitions for the job arbiter: FSM state encoding and the
// default per-job run length.
package job_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2,
        ST_ABORT  = 2'd3
    } state_t;

    localparam int DURATION_DEFAULT = 100;

endpackage

// File: rtl/job_arbiter_duration_timer.sv
// Job duration counter: cleared on job start, advances while enabled and
// flags the last RUN cycle of a job through tc.
module duration_timer
    import job_pkg::*;
#(
    parameter int DURATION = DURATION_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic en,
    output logic tc
);

    // One spare code so the post-terminal increment into FINISH/ABORT never wraps.
    localparam int CNT_W = $clog2(DURATION + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == CNT_W'(DURATION - 1));

endmodule

// File: rtl/job_arbiter.sv
// Round-robin arbiter for one shared timed resource: grants a requester,
// runs its job for DURATION cycles and reports done or aborted.
module job_arbiter
    import job_pkg::*;
#(
    parameter int N        = 4,
    parameter int DURATION = DURATION_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic [N-1:0] kill,
    output logic [N-1:0] grant,
    output logic [N-1:0] done,
    output logic [N-1:0] aborted,
    output logic         busy
);

    localparam int PTR_W = $clog2(N);

    state_t           state;
    state_t           state_next;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] g_idx;
    logic [PTR_W-1:0] g_next_ptr;
    logic [PTR_W-1:0] pick_idx;
    logic             pick_vld;
    logic             kill_g;
    logic             tc;
    logic             timer_start;
    logic             timer_en;

    // Scan downward so the last hit is the smallest offset from rr_ptr.
    always_comb begin
        int j;
        j        = 0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = (int'(rr_ptr) + i) % N;
            if (req[PTR_W'(j)]) begin
                pick_vld = 1'b1;
                pick_idx = PTR_W'(j);
            end
        end
    end

    assign kill_g      = kill[g_idx];
    assign g_next_ptr  = (g_idx == PTR_W'(N - 1)) ? '0 : g_idx + PTR_W'(1);
    assign timer_start = (state == ST_IDLE) && pick_vld;
    assign timer_en    = (state == ST_RUN);

    duration_timer #(
        .DURATION (DURATION)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .start (timer_start),
        .en    (timer_en),
        .tc    (tc)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (pick_vld) state_next = ST_RUN;
            ST_RUN: begin
                if (kill_g)  state_next = ST_ABORT;
                else if (tc) state_next = ST_FINISH;
            end
            ST_FINISH: state_next = ST_IDLE;
            ST_ABORT:  if (!kill_g) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // done/aborted are copies of grant so they can only reach the owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            grant   <= '0;
            done    <= '0;
            aborted <= '0;
            busy    <= 1'b0;
            rr_ptr  <= '0;
            g_idx   <= '0;
        end else begin
            state   <= state_next;
            busy    <= (state_next != ST_IDLE);
            done    <= '0;
            aborted <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        g_idx <= pick_idx;
                        grant <= {{(N-1){1'b0}}, 1'b1} << pick_idx;
                    end else begin
                        grant <= '0;
                    end
                end
                ST_RUN: begin
                    if (kill_g)  aborted <= grant;
                    else if (tc) done    <= grant;
                end
                ST_FINISH: begin
                    grant  <= '0;
                    rr_ptr <= g_next_ptr;
                end
                ST_ABORT: begin
                    if (!kill_g) begin
                        grant  <= '0;
                        rr_ptr <= g_next_ptr;
                    end
                end
                default: grant <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_job_arbiter.sv
// Directed bench for job_arbiter (N=4, DURATION=100): reset, single job,
// foreign kill, abort, kill/terminal race, round-robin fairness, mid-job reset.
module tb_job_arbiter;

    localparam int N   = 4;
    localparam int DUR = 100;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] kill;
    logic [N-1:0] grant;
    logic [N-1:0] done;
    logic [N-1:0] aborted;
    logic         busy;

    int tests = 0;
    int fails = 0;

    job_arbiter #(
        .N        (N),
        .DURATION (DUR)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .kill    (kill),
        .grant   (grant),
        .done    (done),
        .aborted (aborted),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_cycles(input int n, input logic [N-1:0] g, input string tag);
        for (int k = 0; k < n; k++) begin
            tick();
            check({tag, "_grant"}, grant, g);
            check({tag, "_pulse"}, done | aborted, 0);
            check({tag, "_busy"}, busy, 1);
        end
    endtask

    // Called right after the edge that raised grant; ends on the FINISH cycle.
    task automatic run_to_done(input logic [N-1:0] g, input string tag);
        run_cycles(DUR - 1, g, tag);
        tick();
        check({tag, "_done"}, done, g);
        check({tag, "_done_grant"}, grant, g);
        check({tag, "_done_abort"}, aborted, 0);
        check({tag, "_done_busy"}, busy, 1);
    endtask

    logic [N-1:0] rr_order [4];

    initial begin
        rr_order[0] = 4'b0001;
        rr_order[1] = 4'b0010;
        rr_order[2] = 4'b0100;
        rr_order[3] = 4'b1000;

        // reset state, with requests already pending
        rst  = 1'b1;
        req  = 4'b1010;
        kill = 4'b0000;
        tick();
        tick();
        check("rst_grant", grant, 0);
        check("rst_done", done, 0);
        check("rst_aborted", aborted, 0);
        check("rst_busy", busy, 0);

        // first grant after reset goes to lowest requesting index; foreign kills ignored
        rst  = 1'b0;
        kill = 4'b1101;
        tick();
        check("first_grant", grant, 4'b0010);
        check("first_busy", busy, 1);
        run_to_done(4'b0010, "foreign");
        req  = 4'b0000;
        kill = 4'b0000;
        tick();
        check("foreign_end_grant", grant, 0);
        check("foreign_end_done", done, 0);
        check("foreign_end_busy", busy, 0);

        // abort at cnt=40 with kill held 5 cycles
        req = 4'b0010;
        tick();
        check("abort_grant", grant, 4'b0010);
        run_cycles(40, 4'b0010, "abort_run");
        kill = 4'b0010;
        tick();
        check("abort_pulse", aborted, 4'b0010);
        check("abort_no_done", done, 0);
        check("abort_hold_grant", grant, 4'b0010);
        req = 4'b0000;
        run_cycles(4, 4'b0010, "abort_hold");
        kill = 4'b0000;
        req  = 4'b0110;
        tick();
        check("abort_end_grant", grant, 0);
        check("abort_end_pulse", done | aborted, 0);
        check("abort_end_busy", busy, 0);
        tick();
        check("abort_next_grant", grant, 4'b0100);

        // kill in the same cycle as the terminal count: abort wins
        req = 4'b0100;
        run_cycles(DUR - 1, 4'b0100, "race_run");
        kill = 4'b0100;
        tick();
        check("race_aborted", aborted, 4'b0100);
        check("race_no_done", done, 0);
        check("race_grant", grant, 4'b0100);
        kill = 4'b0000;
        req  = 4'b0000;
        tick();
        check("race_end_grant", grant, 0);
        check("race_end_pulse", done | aborted, 0);
        tick();
        check("idle_hold_grant", grant, 0);
        check("idle_hold_busy", busy, 0);

        // fairness: all requesting, four jobs then wrap
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1111;
        tick();
        check("rr_grant0", grant, rr_order[0]);
        for (int j = 0; j < 4; j++) begin
            run_to_done(rr_order[j], "rr_job");
            tick();
            check("rr_gap_grant", grant, 0);
            check("rr_gap_busy", busy, 0);
            tick();
            check("rr_next_grant", grant, rr_order[(j + 1) % 4]);
        end

        // reset in the middle of a job
        run_cycles(50, 4'b0001, "mid_run");
        rst = 1'b1;
        req = 4'b0100;
        tick();
        check("midrst_grant", grant, 0);
        check("midrst_done", done, 0);
        check("midrst_aborted", aborted, 0);
        check("midrst_busy", busy, 0);
        rst = 1'b0;
        tick();
        check("midrst_next_grant", grant, 4'b0100);
        check("midrst_next_busy", busy, 1);
        run_cycles(3, 4'b0100, "midrst_after");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
